// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_pkg: shared widths, requester indices and the write-entry type for the write-back arbiter
package regfile_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREG = 32;
   localparam logic REQ_ALU = 1'b0;
   localparam logic REQ_MEM = 1'b1;
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wbEntry_t;
endpackage

// File: rtl/regfile_wb_arbiter_wb_slot.sv
// wb_slot: one-entry write-back holding slot with valid/ready, grant clear and relative age
module wb_slot
   import regfile_pkg::*;
#(
   parameter logic TIE_YOUNG = 1'b0
) (
   input  logic     Clk,
   input  logic     reset,
   input  logic     inValid,
   input  wbEntry_t inEntry,
   input  logic     grant,
   input  logic     otherHoldV,
   input  logic     otherGrant,
   input  logic     otherLoad,
   output logic     ready,
   output logic     load,
   output logic     holdV,
   output logic     younger,
   output wbEntry_t entry
);
   assign ready = !holdV || grant;
   assign load = inValid && ready;
   // younger is only meaningful while both slots hold; TIE_YOUNG breaks same-edge loads
   always_ff @(posedge Clk or negedge reset)
      if (!reset) begin
         holdV <= 1'b0;
         younger <= 1'b0;
         entry <= '0;
      end else begin
         holdV <= load || (holdV && !grant);
         if (load) entry <= inEntry;
         younger <= load ? ((otherHoldV && !otherGrant) || (otherLoad && TIE_YOUNG)) : (otherLoad ? 1'b0 : younger);
      end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between ALU and load write-back
module regfile_wb_arbiter #(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W,
   parameter int NREG = regfile_pkg::NREG
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic [ADDR_W-1:0] WriteReg,
   output logic [DATA_W-1:0] WriteData,
   output logic              RegWrite,
   output logic [NREG-1:0]   busy,
   output logic              idle
);
   regfile_pkg::wbEntry_t aluEntry, memEntry;
   logic aluHoldV, memHoldV, aluYounger, memYounger, aluLoad, memLoad;
   logic grantAlu, grantMem, sameAddr, rrPtr;
   assign sameAddr = aluEntry.addr == memEntry.addr;
   // same-address pairs go oldest first so the last write to a register wins
   assign grantAlu = aluHoldV && (!memHoldV || (sameAddr ? (memYounger && !aluYounger) : rrPtr == regfile_pkg::REQ_ALU));
   assign grantMem = memHoldV && !grantAlu;
   wb_slot #(.TIE_YOUNG(1'b1)) aluSlot (
      .Clk(Clk), .reset(reset), .inValid(alu_valid), .inEntry({alu_addr, alu_data}),
      .grant(grantAlu), .otherHoldV(memHoldV), .otherGrant(grantMem), .otherLoad(memLoad),
      .ready(alu_ready), .load(aluLoad), .holdV(aluHoldV), .younger(aluYounger), .entry(aluEntry)
   );
   wb_slot #(.TIE_YOUNG(1'b0)) memSlot (
      .Clk(Clk), .reset(reset), .inValid(mem_valid), .inEntry({mem_addr, mem_data}),
      .grant(grantMem), .otherHoldV(aluHoldV), .otherGrant(grantAlu), .otherLoad(aluLoad),
      .ready(mem_ready), .load(memLoad), .holdV(memHoldV), .younger(memYounger), .entry(memEntry)
   );
   always_ff @(posedge Clk or negedge reset)
      if (!reset) begin
         RegWrite <= 1'b0;
         WriteReg <= '0;
         WriteData <= '0;
         rrPtr <= regfile_pkg::REQ_ALU;
      end else begin
         RegWrite <= grantAlu || grantMem;
         if (grantAlu || grantMem) {WriteReg, WriteData} <= grantAlu ? aluEntry : memEntry;
         if (aluHoldV && memHoldV) rrPtr <= !rrPtr;
      end
   always_comb begin
      busy = (aluHoldV ? NREG'(1) << aluEntry.addr : '0) | (memHoldV ? NREG'(1) << memEntry.addr : '0) | (RegWrite ? NREG'(1) << WriteReg : '0);
      idle = !aluHoldV && !memHoldV && !RegWrite;
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized soak checks of the write-back arbiter
module tb_regfile_wb_arbiter;
   logic Clk = 1'b0, reset = 1'b0, alu_valid = 1'b0, mem_valid = 1'b0;
   logic [4:0] alu_addr = '0, mem_addr = '0, WriteReg;
   logic [31:0] alu_data = '0, mem_data = '0, WriteData, busy;
   logic alu_ready, mem_ready, RegWrite, idle;
   int checks = 0, errors = 0, issued = 0;
   logic [36:0] aluQ[$], memQ[$];
   logic [31:0] modelRf[32], dutRf[32];
   logic aluAcc = 1'b0, memAcc = 1'b0;

   always #5 Clk = ~Clk;

   regfile_wb_arbiter dut (
      .Clk(Clk), .reset(reset),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite), .busy(busy), .idle(idle)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic step;
      logic [36:0] w;
      logic hit;
      aluAcc = alu_valid && alu_ready;
      memAcc = mem_valid && mem_ready;
      tick();
      if (memAcc) begin
         memQ.push_back({mem_addr, mem_data});
         modelRf[mem_addr] = mem_data;
      end
      if (aluAcc) begin
         aluQ.push_back({alu_addr, alu_data});
         modelRf[alu_addr] = alu_data;
      end
      if (RegWrite) begin
         w = {WriteReg, WriteData};
         dutRf[WriteReg] = WriteData;
         hit = 1'b1;
         if (aluQ.size() > 0 && aluQ[0] == w) void'(aluQ.pop_front());
         else if (memQ.size() > 0 && memQ[0] == w) void'(memQ.pop_front());
         else hit = 1'b0;
         chk("soak_write_known", 64'(hit), 64'd1);
      end
   endtask

   initial begin
      tick();
      chk("rst_regwrite", 64'(RegWrite), 64'd0);
      chk("rst_writereg", 64'(WriteReg), 64'd0);
      chk("rst_writedata", 64'(WriteData), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_idle", 64'(idle), 64'd1);
      chk("rst_ready", 64'({alu_ready, mem_ready}), 64'd3);
      reset = 1'b1;
      tick();
      // single ALU write to r5
      alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h0000_1234;
      chk("single_ready", 64'(alu_ready), 64'd1);
      tick();
      alu_valid = 1'b0;
      chk("single_busy_k", 64'(busy), 64'h20);
      chk("single_nowrite_k", 64'(RegWrite), 64'd0);
      chk("single_notidle", 64'(idle), 64'd0);
      tick();
      chk("single_regwrite", 64'(RegWrite), 64'd1);
      chk("single_writereg", 64'(WriteReg), 64'd5);
      chk("single_writedata", 64'(WriteData), 64'h1234);
      chk("single_busy_k1", 64'(busy), 64'h20);
      tick();
      chk("single_done", 64'(RegWrite), 64'd0);
      chk("single_busy_k2", 64'(busy), 64'd0);
      chk("single_hold_reg", 64'(WriteReg), 64'd5);
      chk("single_idle", 64'(idle), 64'd1);
      // contention: both continuously valid, distinct addresses
      alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hA1;
      mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'hB1;
      tick();
      chk("cont_ready0", 64'({alu_ready, mem_ready}), 64'b10);
      for (int j = 1; j <= 4; j++) begin
         tick();
         chk("cont_regwrite", 64'(RegWrite), 64'd1);
         chk("cont_writereg", 64'(WriteReg), (j % 2 == 1) ? 64'd3 : 64'd7);
         chk("cont_ready", 64'({alu_ready, mem_ready}), (j % 2 == 1) ? 64'b01 : 64'b10);
      end
      // reset mid-cycle with both slots full
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_regwrite", 64'(RegWrite), 64'd0);
      chk("midrst_writereg", 64'(WriteReg), 64'd0);
      chk("midrst_idle", 64'(idle), 64'd1);
      chk("midrst_ready", 64'({alu_ready, mem_ready}), 64'd3);
      alu_valid = 1'b0; mem_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      chk("midrst_nopulse1", 64'(RegWrite), 64'd0);
      tick();
      chk("midrst_nopulse2", 64'(RegWrite), 64'd0);
      // ordering: MEM r9 then ALU r9 on the next edge
      mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'hA;
      tick();
      mem_valid = 1'b0;
      alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'hB;
      chk("order_alu_ready", 64'(alu_ready), 64'd1);
      tick();
      alu_valid = 1'b0;
      chk("order_first", 64'({RegWrite, WriteReg, WriteData}), {1'b1, 5'd9, 32'hA});
      tick();
      chk("order_second", 64'({RegWrite, WriteReg, WriteData}), {1'b1, 5'd9, 32'hB});
      tick();
      chk("order_done", 64'(RegWrite), 64'd0);
      // same-edge loads to one address: MEM is older and wins over the ALU pointer
      alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'hD;
      mem_valid = 1'b1; mem_addr = 5'd12; mem_data = 32'hC;
      tick();
      alu_valid = 1'b0; mem_valid = 1'b0;
      chk("tie_ready", 64'({alu_ready, mem_ready}), 64'b01);
      chk("tie_busy", 64'(busy), 64'h1000);
      tick();
      chk("tie_first", 64'({RegWrite, WriteData}), {1'b1, 32'hC});
      tick();
      chk("tie_second", 64'({RegWrite, WriteData}), {1'b1, 32'hD});
      tick();
      chk("tie_idle", 64'(idle), 64'd1);
      // randomized soak with gaps and backpressure
      for (int i = 0; i < 32; i++) begin
         modelRf[i] = '0;
         dutRf[i] = '0;
      end
      aluAcc = 1'b0; memAcc = 1'b0;
      for (int c = 0; c < 20000 && (issued < 1000 || alu_valid || mem_valid); c++) begin
         if (!alu_valid || aluAcc) begin
            if (issued < 1000 && $urandom_range(0, 2) != 0) begin
               alu_valid = 1'b1; alu_addr = 5'($urandom_range(0, 7)); alu_data = $urandom; issued++;
            end else alu_valid = 1'b0;
         end
         if (!mem_valid || memAcc) begin
            if (issued < 1000 && $urandom_range(0, 2) != 0) begin
               mem_valid = 1'b1; mem_addr = 5'($urandom_range(0, 7)); mem_data = $urandom; issued++;
            end else mem_valid = 1'b0;
         end
         step();
      end
      chk("soak_issued", 64'(issued), 64'd1000);
      chk("soak_drained_inputs", 64'({alu_valid, mem_valid}), 64'd0);
      repeat (4) step();
      chk("soak_alu_queue_empty", 64'(aluQ.size()), 64'd0);
      chk("soak_mem_queue_empty", 64'(memQ.size()), 64'd0);
      chk("soak_idle", 64'(idle), 64'd1);
      for (int i = 0; i < 8; i++) chk("soak_regfile", 64'({i[4:0], dutRf[i]}), 64'({i[4:0], modelRf[i]}));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32×32 register file's single write port. It shares that port between two requesters: the ALU write-back path and the memory/load write-back path. Each requester has a one-entry holding slot with a valid/ready handshake. The block grants at most one write per cycle and drives the register file's WriteReg/WriteData/RegWrite from registers. It also exports a per-register pending-write vector so issue logic can stall reads of registers whose write has not yet landed.

## Interface
Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register index width
- NREG, 32, register count (must equal 2**ADDR_W)

Ports:
- Clk  in  1  clock; all state changes on posedge
- reset  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU write request
- alu_ready  out  1  ALU slot can accept this cycle
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load write request
- mem_ready  out  1  load slot can accept this cycle
- mem_addr  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- WriteReg  out  ADDR_W  to register file
- WriteData  out  DATA_W  to register file
- RegWrite  out  1  to register file; high for exactly one cycle per granted write
- busy  out  NREG  bit i set while a write to register i is pending
- idle  out  1  no slot valid and RegWrite low

## Operation
- Handshake: a transfer occurs on posedge when valid && ready. valid and its payload are held until accepted. ready never depends combinationally on valid.
- Slot: each requester has a slot with hold_v, hold_addr, hold_data, age.
  - ready = !hold_v || (slot granted this cycle).
  - An accept loads the slot. A grant without an accept clears hold_v.
- Grant, combinational from slot state only:
  - No slot valid: no grant.
  - One slot valid: grant it.
  - Both valid, same address: grant the older slot, even against the round-robin pointer. This preserves write order, so the last write wins.
  - Both valid, different addresses: round-robin. The pointer names the preferred requester and flips to the other after every two-valid grant.
- Age: a slot loaded while the other slot is already valid is the younger one. If both load on the same edge, MEM is the older.
- Output stage: on a grant, the next posedge sets WriteReg/WriteData to the granted entry and RegWrite=1. With no grant, RegWrite=0 and WriteReg/WriteData hold their values.
- busy[i]: set if either slot is valid with addr i, or RegWrite && WriteReg==i. Combinational from registers.

## Timing
- Reset (async, immediate) values:
  - RegWrite=0, WriteReg=0, WriteData=0.
  - Both slots empty; busy=0, idle=1, alu_ready=mem_ready=1.
  - Round-robin pointer = ALU.
- Reset mid-operation discards held writes; no RegWrite pulses before a fresh handshake.
- Latency: handshake at edge k → RegWrite high between edges k+1 and k+2. The register file commits on the negedge inside that window.
- busy[i] rises after edge k and falls at edge k+2 unless another write to i is pending.
- Throughput: one write per cycle. When both requesters are continuously valid, each receives a grant every second cycle. Maximum wait for a granted slot is one cycle.
- Simultaneous grant and accept on the same slot: the slot reloads with no bubble and ready stays 1.
- Outputs change only on posedge or on reset assertion. They are stable across the negedge.

## Structure
- Package regfile_pkg holds:
  - DATA_W, ADDR_W, NREG.
  - Requester indices REQ_ALU=0, REQ_MEM=1.
  - The write-entry struct (addr, data).
- Sub-module wb_slot: the one-entry holding register with valid/ready, load, clear and age. It is instantiated twice.
- Grant logic, round-robin pointer, output register and busy decode live in the top.

## Test plan
- Reset: assert reset=0 mid-cycle → RegWrite=0, WriteReg=0, WriteData=0, busy=0, idle=1, both ready=1 immediately.
- Single write, alu addr 5 data 0x00001234 accepted at edge k → RegWrite=1, WriteReg=5, WriteData=0x00001234 for one cycle after edge k+1; busy[5] high from edge k to edge k+2.
- Contention: both valid continuously, alu addr 3, mem addr 7 → grants alternate ALU, MEM, ALU, ...; RegWrite high every cycle; each ready toggles 1,0,1,0.
- Ordering: mem addr 9 data 0xA accepted at edge 0, alu addr 9 data 0xB at edge 1, pointer=ALU → MEM write issued before ALU write; model register 9 = 0xB afterwards.
- Backpressure soak: 1000 random transactions with random valid gaps → no drop or duplicate; per-address write order matches a reference model; payload held while ready=0.
- Reset mid-stream: both slots full, reset pulsed → busy=0 at once; no RegWrite until a new handshake after release.
